dictionary_buffer: RTL and testbench
====================================

# dictionary_buffer

- Upstream neighbour of `word_comparator` in the Stage1 compressor.
- Holds a FIFO-replacement dictionary of 32-bit words and presents every entry in parallel, with per-entry valid bits, to the comparator bank.
- Accepts new words from the compressor's decision logic through a push handshake.
- Supports a multi-cycle flush that clears entries one per cycle.

## Interface
Parameters:
- COMPARE_WORD, 32, width of one dictionary entry; must equal `word_comparator` COMPARE_WORD.
- DICT_ENTRIES, 16, number of entries; power of two, ≥ 2.

Ports:
- i_clk  input  1  single clock; all state on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_push  input  1  request to write i_word into the dictionary.
- i_word  input  COMPARE_WORD  word to insert.
- o_ready  output  1  high when a push can be accepted.
- i_clear  input  1  request a full dictionary flush; single-cycle pulse.
- o_dict  output  DICT_ENTRIES*COMPARE_WORD  flattened entries; entry k is at bits [k*COMPARE_WORD +: COMPARE_WORD].
- o_entry_valid  output  DICT_ENTRIES  bit k high when entry k holds a pushed word.
- o_count  output  $clog2(DICT_ENTRIES)+1  number of valid entries; saturates at DICT_ENTRIES.
- o_wr_ptr  output  $clog2(DICT_ENTRIES)  index of the next entry to be written.
- o_full  output  1  high when o_count == DICT_ENTRIES.

## Operation
- **States:** READY and CLEARING. Reset state is READY.
- **READY:**
  - o_ready = 1.
  - A push is accepted when i_push && o_ready.
  - An accepted push writes i_word to entry o_wr_ptr and sets that entry's valid bit.
  - o_wr_ptr increments modulo DICT_ENTRIES: DICT_ENTRIES-1 wraps to 0.
  - o_count increments unless already DICT_ENTRIES.
  - When full, a push overwrites the oldest entry (the one at o_wr_ptr); o_count stays DICT_ENTRIES.
- **i_clear in READY:**
  - Go to CLEARING and load clear index = 0.
  - Any push in the same cycle is dropped: clear wins.
- **CLEARING:**
  - o_ready = 0; i_push is ignored.
  - Each cycle, entry[clear index] is set to 0, its valid bit is cleared, and the clear index increments.
  - After entry DICT_ENTRIES-1 is cleared: o_wr_ptr = 0, o_count = 0, return to READY.
  - i_clear during CLEARING is ignored; the flush does not restart.
- **Reset at any time, including mid-CLEARING:**
  - All entries 0, o_entry_valid = 0, o_count = 0, o_wr_ptr = 0, o_full = 0.
  - State READY, o_ready = 1.
- **Invalid entries** present a data value of 0. Downstream must qualify matches with o_entry_valid.

## Timing
- **Push latency:** a word accepted at edge N appears on o_dict, o_entry_valid, o_count and o_wr_ptr after edge N. All outputs are registered.
- **o_ready** is a combinational decode of the state register only; it has no path from i_push or i_clear.
- **Flush timing:** i_clear sampled at edge N.
  - o_ready is low from edge N through edge N+DICT_ENTRIES.
  - Entry k is cleared at edge N+1+k.
  - o_ready is high again after edge N+DICT_ENTRIES.
- **o_full** is derived from the o_count register in the same cycle.
- **Back-to-back pushes:** one per cycle, sustained indefinitely in READY.

## Configuration
- Macro: DICT_DUP_SKIP_EN.
- **Defined:** an accepted push whose i_word equals the most recently written entry (entry o_wr_ptr-1 mod DICT_ENTRIES, valid bit set) is consumed but does not change any state. o_ready is unaffected.
- **Not defined:** every accepted push writes, including duplicates.

## Structure
- Shared package `compress_pkg` holds:
  - COMPARE_WORD and DICT_ENTRIES defaults;
  - the BYTE = 8 constant;
  - the state typedef `dict_state_t` {DICT_READY, DICT_CLEARING}.
- One natural sub-module, `dict_entry`: a COMPARE_WORD register plus valid bit, with write-enable, clear-enable and async reset. Instantiate it DICT_ENTRIES times in a generate loop. Pointer, count and FSM stay in the top module.

## Test plan
1. **Reset:** hold i_reset high 2 cycles → o_ready = 1, o_count = 0, o_wr_ptr = 0, o_entry_valid = 0, o_full = 0, o_dict all zero.
2. **Basic push:** push 32'hAAAAAAAA, then 32'h55AA33CC → entry0 = AAAAAAAA, entry1 = 55AA33CC, o_entry_valid = 16'h0003, o_count = 2, o_wr_ptr = 2.
3. **Wrap and overwrite:**
   - Push 16 distinct words 32'h1000_0000+k → o_full = 1, o_wr_ptr = 0.
   - 17th push of 32'hDEADBEEF → entry0 = DEADBEEF, o_count = 16, o_wr_ptr = 1.
4. **Flush:**
   - From full, pulse i_clear with i_push = 1 in the same cycle → the push is dropped.
   - o_ready is low for 16 cycles and entries clear in index order.
   - Then o_count = 0, o_wr_ptr = 0, o_ready = 1.
5. **Reset mid-flush:** assert i_reset at clear cycle 5 → all outputs return to their reset values immediately; a push on the first cycle after reset lands in entry0.
6. **Duplicate skip:** push 32'hAABBCCDD twice.
   - With DICT_DUP_SKIP_EN: o_count = 1, o_wr_ptr = 1.
   - Without it: o_count = 2, o_wr_ptr = 2.

Source files
------------

// File: rtl/compress_pkg.sv
// Shared definitions for the Stage1 compressor: default dictionary geometry,
// byte width and the dictionary buffer state encoding.
package compress_pkg;

  localparam int COMPARE_WORD_DEF = 32;
  localparam int DICT_ENTRIES_DEF = 16;
  localparam int BYTE             = 8;

  typedef enum logic {
    DICT_READY    = 1'b0,
    DICT_CLEARING = 1'b1
  } dict_state_t;

endpackage

// File: rtl/dict_entry.sv
// One dictionary slot: a data word plus its valid bit.
// Clear takes priority over write so a flush always leaves the slot empty.
module dict_entry #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr_en,
  input  logic             i_clr_en,
  input  logic [WIDTH-1:0] i_word,
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid
);

  // Slot storage; invalid slots always hold zero.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_word  <= '0;
      o_valid <= 1'b0;
    end else if (i_clr_en) begin
      o_word  <= '0;
      o_valid <= 1'b0;
    end else if (i_wr_en) begin
      o_word  <= i_word;
      o_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/dictionary_buffer.sv
// FIFO-replacement dictionary feeding the word_comparator bank. All entries
// are presented in parallel with valid bits; a flush clears one entry per
// cycle. Optional macro DICT_DUP_SKIP_EN: a push equal to the most recently
// written valid entry is consumed without changing any state.
//
// state         | meaning
// --------------+---------------------------------------------------------
// DICT_READY    | accepting pushes, o_ready high
// DICT_CLEARING | flushing entry clr_idx each cycle, pushes and clears ignored
module dictionary_buffer
  import compress_pkg::*;
#(
  parameter int COMPARE_WORD = COMPARE_WORD_DEF,
  parameter int DICT_ENTRIES = DICT_ENTRIES_DEF
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_push,
  input  logic [COMPARE_WORD-1:0]            i_word,
  output logic                               o_ready,
  input  logic                               i_clear,
  output logic [DICT_ENTRIES*COMPARE_WORD-1:0] o_dict,
  output logic [DICT_ENTRIES-1:0]            o_entry_valid,
  output logic [$clog2(DICT_ENTRIES):0]      o_count,
  output logic [$clog2(DICT_ENTRIES)-1:0]    o_wr_ptr,
  output logic                               o_full
);

  localparam int IDX_W = $clog2(DICT_ENTRIES);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DICT_ENTRIES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DICT_ENTRIES - 1);

  dict_state_t state, state_next;
  logic [IDX_W-1:0] wr_ptr, clr_idx;
  logic [CNT_W-1:0] count;
  logic push_acc, push_wr, dup_hit, clr_last;

  logic [COMPARE_WORD-1:0] ent_word [DICT_ENTRIES];
  logic [DICT_ENTRIES-1:0] ent_valid, wr_en, clr_en;

  // Next-state decode; o_ready depends on the state register only.
  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    push_acc   = 1'b0;
    clr_last   = 1'b0;
    case (state)
      DICT_READY: begin
        o_ready = 1'b1;
        if (i_clear) state_next = DICT_CLEARING;
        else         push_acc   = i_push;
      end
      DICT_CLEARING: begin
        clr_last = (clr_idx == IDX_LAST);
        if (clr_last) state_next = DICT_READY;
      end
      default: state_next = DICT_READY;
    endcase
  end

`ifdef DICT_DUP_SKIP_EN
  logic [IDX_W-1:0] last_idx;
  assign last_idx = wr_ptr - IDX_W'(1);
  assign dup_hit  = ent_valid[last_idx] && (ent_word[last_idx] == i_word);
`else
  assign dup_hit  = 1'b0;
`endif

  assign push_wr = push_acc && !dup_hit;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= DICT_READY;
    else         state <= state_next;
  end

  // Flush index: restarts at 0 on a clear request, walks up while clearing.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                                 clr_idx <= '0;
    else if (state == DICT_READY && i_clear)     clr_idx <= '0;
    else if (state == DICT_CLEARING)             clr_idx <= clr_idx + IDX_W'(1);
  end

  // Write pointer and occupancy count; count saturates once the ring is full.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr_last) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push_wr) begin
      wr_ptr <= wr_ptr + IDX_W'(1);
      if (count != CNT_MAX) count <= count + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < DICT_ENTRIES; k++) begin : g_entry
    assign wr_en[k]  = push_wr && (wr_ptr == IDX_W'(k));
    assign clr_en[k] = (state == DICT_CLEARING) && (clr_idx == IDX_W'(k));

    dict_entry #(.WIDTH(COMPARE_WORD)) u_entry (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_wr_en (wr_en[k]),
      .i_clr_en(clr_en[k]),
      .i_word  (i_word),
      .o_word  (ent_word[k]),
      .o_valid (ent_valid[k])
    );

    assign o_dict[k*COMPARE_WORD +: COMPARE_WORD] = ent_word[k];
  end

  assign o_entry_valid = ent_valid;
  assign o_count       = count;
  assign o_wr_ptr      = wr_ptr;
  assign o_full        = (count == CNT_MAX);

endmodule

// File: tb/tb_dictionary_buffer.sv
module tb_dictionary_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         push;
  logic [31:0]  word;
  logic         ready;
  logic         clear;
  logic [511:0] dict;
  logic [15:0]  valid;
  logic [4:0]   count;
  logic [3:0]   wr_ptr;
  logic         full;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        push;
    logic [31:0] word;
    logic [4:0]  exp_count;
    logic [3:0]  exp_ptr;
    logic [15:0] exp_valid;
    logic        exp_ready;
    int          chk_idx;
    logic [31:0] chk_word;
  } vec_t;

  vec_t vecs [4];

  dictionary_buffer #(.COMPARE_WORD(32), .DICT_ENTRIES(16)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_push       (push),
    .i_word       (word),
    .o_ready      (ready),
    .i_clear      (clear),
    .o_dict       (dict),
    .o_entry_valid(valid),
    .o_count      (count),
    .o_wr_ptr     (wr_ptr),
    .o_full       (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int k);
    return dict[k*32 +: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    push  = 1'b0;
    clear = 1'b0;
    word  = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_v;
    rst = 1'b1; push = 1'b0; clear = 1'b0; word = '0;

    vecs[0] = '{1'b1, 32'hAAAAAAAA, 5'd1, 4'd1, 16'h0001, 1'b1, 0, 32'hAAAAAAAA};
    vecs[1] = '{1'b1, 32'h55AA33CC, 5'd2, 4'd2, 16'h0003, 1'b1, 1, 32'h55AA33CC};
    vecs[2] = '{1'b0, 32'hFFFFFFFF, 5'd2, 4'd2, 16'h0003, 1'b1, 2, 32'h00000000};
    vecs[3] = '{1'b1, 32'h01234567, 5'd3, 4'd3, 16'h0007, 1'b1, 2, 32'h01234567};

    // Reset values
    do_reset();
    chk("reset ready", {31'b0, ready}, 32'd1);
    chk("reset count", {27'b0, count}, 32'd0);
    chk("reset wr_ptr", {28'b0, wr_ptr}, 32'd0);
    chk("reset valid", {16'b0, valid}, 32'd0);
    chk("reset full", {31'b0, full}, 32'd0);
    chk("reset dict zero", {31'b0, |dict}, 32'd0);

    // Table-driven basic pushes
    for (int i = 0; i < 4; i++) begin
      push = vecs[i].push;
      word = vecs[i].word;
      step();
      chk($sformatf("vec%0d count", i), {27'b0, count}, {27'b0, vecs[i].exp_count});
      chk($sformatf("vec%0d wr_ptr", i), {28'b0, wr_ptr}, {28'b0, vecs[i].exp_ptr});
      chk($sformatf("vec%0d valid", i), {16'b0, valid}, {16'b0, vecs[i].exp_valid});
      chk($sformatf("vec%0d ready", i), {31'b0, ready}, {31'b0, vecs[i].exp_ready});
      chk($sformatf("vec%0d entry", i), ent(vecs[i].chk_idx), vecs[i].chk_word);
    end
    push = 1'b0;

    // Fill, wrap and overwrite the oldest entry
    do_reset();
    for (int k = 0; k < 16; k++) begin
      push = 1'b1;
      word = 32'h1000_0000 + 32'(k);
      step();
      chk($sformatf("fill%0d count", k), {27'b0, count}, 32'(k + 1));
      chk($sformatf("fill%0d wr_ptr", k), {28'b0, wr_ptr}, 32'((k + 1) % 16));
      chk($sformatf("fill%0d entry", k), ent(k), 32'h1000_0000 + 32'(k));
    end
    chk("fill full", {31'b0, full}, 32'd1);
    word = 32'hDEADBEEF;
    step();
    chk("wrap entry0", ent(0), 32'hDEADBEEF);
    chk("wrap entry1", ent(1), 32'h10000001);
    chk("wrap count", {27'b0, count}, 32'd16);
    chk("wrap wr_ptr", {28'b0, wr_ptr}, 32'd1);
    chk("wrap full", {31'b0, full}, 32'd1);

    // Flush from full; a simultaneous push is dropped, pushes and a second
    // clear during the flush are ignored
    word  = 32'h12345678;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("flush start ready", {31'b0, ready}, 32'd0);
    chk("flush dropped push", ent(1), 32'h10000001);
    chk("flush start count", {27'b0, count}, 32'd16);
    chk("flush start valid", {16'b0, valid}, 32'h0000FFFF);
    for (int c = 0; c < 16; c++) begin
      clear = (c == 3);
      step();
      exp_v = 16'hFFFF << (c + 1);
      chk($sformatf("flush%0d entry", c), ent(c), 32'd0);
      chk($sformatf("flush%0d valid", c), {16'b0, valid}, {16'b0, exp_v});
      chk($sformatf("flush%0d ready", c), {31'b0, ready}, (c == 15) ? 32'd1 : 32'd0);
      chk($sformatf("flush%0d count", c), {27'b0, count}, (c == 15) ? 32'd0 : 32'd16);
    end
    clear = 1'b0;
    push  = 1'b0;
    chk("flush end wr_ptr", {28'b0, wr_ptr}, 32'd0);
    chk("flush end full", {31'b0, full}, 32'd0);
    chk("flush end dict zero", {31'b0, |dict}, 32'd0);
    step();
    chk("post flush ready", {31'b0, ready}, 32'd1);
    chk("post flush count", {27'b0, count}, 32'd0);

    // Reset in the middle of a flush
    for (int k = 0; k < 3; k++) begin
      push = 1'b1;
      word = 32'hA0 + 32'(k);
      step();
    end
    push  = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int c = 0; c < 5; c++) step();
    chk("midflush count before", {27'b0, count}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("midflush ready", {31'b0, ready}, 32'd1);
    chk("midflush count", {27'b0, count}, 32'd0);
    chk("midflush wr_ptr", {28'b0, wr_ptr}, 32'd0);
    chk("midflush valid", {16'b0, valid}, 32'd0);
    chk("midflush full", {31'b0, full}, 32'd0);
    chk("midflush dict zero", {31'b0, |dict}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    push = 1'b1;
    word = 32'h0BADF00D;
    step();
    push = 1'b0;
    chk("post reset entry0", ent(0), 32'h0BADF00D);
    chk("post reset count", {27'b0, count}, 32'd1);
    chk("post reset wr_ptr", {28'b0, wr_ptr}, 32'd1);
    chk("post reset valid", {16'b0, valid}, 32'h00000001);

    // Duplicate push
    do_reset();
    push = 1'b1;
    word = 32'hAABBCCDD;
    step();
    step();
    push = 1'b0;
    step();
`ifdef DICT_DUP_SKIP_EN
    chk("dup count", {27'b0, count}, 32'd1);
    chk("dup wr_ptr", {28'b0, wr_ptr}, 32'd1);
    chk("dup entry1", ent(1), 32'd0);
`else
    chk("dup count", {27'b0, count}, 32'd2);
    chk("dup wr_ptr", {28'b0, wr_ptr}, 32'd2);
    chk("dup entry1", ent(1), 32'hAABBCCDD);
`endif
    chk("dup entry0", ent(0), 32'hAABBCCDD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
